// File: rtl/sdram_init_refresh_ctrl.sv
`default_nettype none
// sdram_init_refresh_ctrl: registered host command decode, power-up init
// sequencer (PRECHARGE / AUTO REFRESH x N / LOAD MODE) and refresh-debt scheduler.
module sdram_init_refresh_ctrl #(
  parameter int ASIZE        = 22,
  parameter int TW           = 16,
  parameter int INIT_PER     = 24000,
  parameter int CMD_GAP      = 20,
  parameter int INIT_REFS    = 8,
  parameter int REF_PER      = 1536,
  parameter int REF_MAX_DEBT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cmd_i,
  input  logic [ASIZE-1:0] addr_i,
  input  logic             cm_ack_i,
  input  logic             ref_ack_i,
  input  logic             init_restart_i,
  output logic             nop_o,
  output logic             reada_o,
  output logic             writea_o,
  output logic [ASIZE-1:0] saddr_o,
  output logic             cmd_ack_o,
  output logic             precharge_o,
  output logic             refresh_o,
  output logic             load_mode_o,
  output logic             ref_req_o,
  output logic             ref_urgent_o,
  output logic [3:0]       ref_debt_o,
  output logic             init_done_o
);

  localparam logic [TW-1:0] WAIT_LAST = TW'(INIT_PER - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(CMD_GAP - 1);
  localparam logic [TW-1:0] REF_LAST  = TW'(REF_PER - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [3:0]    REFS_LAST = 4'(INIT_REFS - 1);
  localparam logic [3:0]    DEBT_MAX  = 4'(REF_MAX_DEBT);
  localparam logic [3:0]    DEBT_URG  = 4'(REF_MAX_DEBT - 1);

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_PRE  = 3'd1,
    S_REF  = 3'd2,
    S_MRS  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [3:0]       refcnt_q, refcnt_d;
  logic             precharge_q, precharge_d;
  logic             refresh_q, refresh_d;
  logic             load_mode_q, load_mode_d;
  logic             init_done_q, init_done_d;
  logic [TW-1:0]    ref_tmr_q, ref_tmr_d;
  logic [3:0]       debt_q, debt_d;
  logic             ref_req_q, ref_req_d;
  logic             ref_urgent_q, ref_urgent_d;
  logic             nop_q, nop_d;
  logic             reada_q, reada_d;
  logic             writea_q, writea_d;
  logic [ASIZE-1:0] saddr_q, saddr_d;
  logic             cmd_ack_q, cmd_ack_d;

  logic gap_hit;
  logic ref_tick;
  logic ack_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT;
      timer_q      <= '0;
      refcnt_q     <= '0;
      precharge_q  <= 1'b0;
      refresh_q    <= 1'b0;
      load_mode_q  <= 1'b0;
      init_done_q  <= 1'b0;
      ref_tmr_q    <= '0;
      debt_q       <= '0;
      ref_req_q    <= 1'b0;
      ref_urgent_q <= 1'b0;
      nop_q        <= 1'b0;
      reada_q      <= 1'b0;
      writea_q     <= 1'b0;
      saddr_q      <= '0;
      cmd_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      refcnt_q     <= refcnt_d;
      precharge_q  <= precharge_d;
      refresh_q    <= refresh_d;
      load_mode_q  <= load_mode_d;
      init_done_q  <= init_done_d;
      ref_tmr_q    <= ref_tmr_d;
      debt_q       <= debt_d;
      ref_req_q    <= ref_req_d;
      ref_urgent_q <= ref_urgent_d;
      nop_q        <= nop_d;
      reada_q      <= reada_d;
      writea_q     <= writea_d;
      saddr_q      <= saddr_d;
      cmd_ack_q    <= cmd_ack_d;
    end
  end

  // One timer serves both the power-up wait and the inter-strobe gap; it is
  // cleared on every phase change so each strobe lands exactly CMD_GAP apart.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    refcnt_d    = refcnt_q;
    precharge_d = 1'b0;
    refresh_d   = 1'b0;
    load_mode_d = 1'b0;
    init_done_d = init_done_q;
    gap_hit     = (timer_q == GAP_LAST);

    case (state_q)
      S_WAIT: begin
        if (timer_q == WAIT_LAST) begin
          state_d = S_PRE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      S_PRE: begin
        if (gap_hit) begin
          precharge_d = 1'b1;
          state_d     = S_REF;
          timer_d     = '0;
          refcnt_d    = '0;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      S_REF: begin
        if (gap_hit) begin
          refresh_d = 1'b1;
          timer_d   = '0;
          if (refcnt_q == REFS_LAST) begin
            state_d = S_MRS;
          end else begin
            refcnt_d = refcnt_q + 4'd1;
          end
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      S_MRS: begin
        if (gap_hit) begin
          load_mode_d = 1'b1;
          state_d     = S_DONE;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      S_DONE: begin
        init_done_d = 1'b1;
      end
      default: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
    endcase

    if (init_restart_i) begin
      state_d     = S_WAIT;
      timer_d     = '0;
      refcnt_d    = '0;
      precharge_d = 1'b0;
      refresh_d   = 1'b0;
      load_mode_d = 1'b0;
      init_done_d = 1'b0;
    end
  end

  // Refresh timer idles at REF_PER-1 until init completes, so the first tick
  // lands exactly REF_PER cycles after INIT_DONE rises.
  always_comb begin
    ref_tick = init_done_q && (ref_tmr_q == '0);
    ack_ok   = ref_ack_i && init_done_q;
    debt_d   = debt_q;

    if (!init_done_q || ref_tick) begin
      ref_tmr_d = REF_LAST;
    end else begin
      ref_tmr_d = ref_tmr_q - TMR_ONE;
    end

    if (ref_tick && !ack_ok) begin
      if (debt_q != DEBT_MAX) begin
        debt_d = debt_q + 4'd1;
      end
    end else if (ack_ok && !ref_tick && (debt_q != 4'd0)) begin
      debt_d = debt_q - 4'd1;
    end

    if (init_restart_i) begin
      ref_tmr_d = '0;
      debt_d    = '0;
    end

    ref_req_d    = (debt_d != 4'd0);
    ref_urgent_d = (debt_d >= DEBT_URG);
  end

  // Gating on the next INIT_DONE keeps READA/WRITEA aligned with the level
  // they are qualified by, including the cycle a restart drops it.
  always_comb begin
    nop_d     = (cmd_i == 2'b00) || (cmd_i == 2'b11);
    reada_d   = (cmd_i == 2'b01) && init_done_d;
    writea_d  = (cmd_i == 2'b10) && init_done_d;
    saddr_d   = addr_i;
    cmd_ack_d = cm_ack_i && !cmd_ack_q;
  end

  assign nop_o        = nop_q;
  assign reada_o      = reada_q;
  assign writea_o     = writea_q;
  assign saddr_o      = saddr_q;
  assign cmd_ack_o    = cmd_ack_q;
  assign precharge_o  = precharge_q;
  assign refresh_o    = refresh_q;
  assign load_mode_o  = load_mode_q;
  assign ref_req_o    = ref_req_q;
  assign ref_urgent_o = ref_urgent_q;
  assign ref_debt_o   = debt_q;
  assign init_done_o  = init_done_q;

endmodule
`default_nettype wire
